p2_stride_seq: RTL and testbench

// - Power-of-two stride sequencer with valid/ready handshakes on both sides, for the slide unit (SLDU).
// - Accepts one stride per transaction and holds it in a residual register.
// - Emits the stride's set bits one per beat, as one-hot power-of-two strides.
// - Emission order is selectable per transaction (LSB-first or MSB-first); the consumer performs one shift per beat.

---
 rtl/p2_stride_seq_pkg.sv | 11 +
 rtl/p2_stride_seq_if.sv | 30 +++
 rtl/p2_stride_seq_pick.sv | 35 +++
 rtl/p2_stride_seq.sv | 118 +++++++++++
 tb/tb_p2_stride_seq.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/p2_stride_seq_pkg.sv
// Shared types and helpers for the power-of-two stride sequencer.
package p2_stride_seq_pkg;

  typedef enum logic {P2_LSB_FIRST, P2_MSB_FIRST} p2_order_e;

  // Index width for an n-entry range, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/p2_stride_seq_if.sv
// Stride request and one-hot beat channels of the stride sequencer.
interface p2_stride_seq_if
  import p2_stride_seq_pkg::*;
#(
  parameter int unsigned StrideWidth = idx_width(32),
  parameter int unsigned IdxWidth    = idx_width(StrideWidth)
) ();

  logic [StrideWidth-1:0] stride;
  p2_order_e              order;
  logic                   stride_valid;
  logic                   stride_ready;
  logic [StrideWidth-1:0] p2_stride;
  logic [IdxWidth-1:0]    p2_idx;
  logic                   p2_last;
  logic                   p2_valid;
  logic                   p2_ready;
  logic [IdxWidth:0]      popc;

  modport master (
    output stride, order, stride_valid, p2_ready,
    input  stride_ready, p2_stride, p2_idx, p2_last, p2_valid, popc
  );

  modport slave (
    input  stride, order, stride_valid, p2_ready,
    output stride_ready, p2_stride, p2_idx, p2_last, p2_valid, popc
  );

endinterface

// File: rtl/p2_stride_seq_pick.sv
// Combinational picker: selects the lowest or highest set bit of the residual
// and flags whether it is the last one.
module p2_stride_pick
  import p2_stride_seq_pkg::*;
#(
  parameter int unsigned StrideWidth = 5,
  parameter int unsigned IdxWidth    = idx_width(StrideWidth)
) (
  input  logic [StrideWidth-1:0] residual_i,
  input  p2_order_e              order_i,
  output logic [StrideWidth-1:0] onehot_o,
  output logic [IdxWidth-1:0]    idx_o,
  output logic                   last_o,
  output logic                   empty_o
);

  logic [IdxWidth:0] popc;

  // Later loop iterations win, so each scan runs towards the bit it prefers.
  always_comb begin
    popc  = '0;
    idx_o = '0;
    for (int i = 0; i < StrideWidth; i++) begin
      popc = popc + (IdxWidth+1)'(residual_i[i]);
      if (residual_i[i] && order_i == P2_MSB_FIRST) idx_o = IdxWidth'(i);
    end
    for (int i = StrideWidth - 1; i >= 0; i--) begin
      if (residual_i[i] && order_i == P2_LSB_FIRST) idx_o = IdxWidth'(i);
    end
    empty_o  = (residual_i == '0);
    last_o   = (popc == (IdxWidth+1)'(1));
    onehot_o = empty_o ? '0 : (StrideWidth'(1) << idx_o);
  end

endmodule

// File: rtl/p2_stride_seq.sv
// Power-of-two stride sequencer: emits each set bit of an accepted stride as a
// one-hot beat. Define P2_STRIDE_SEQ_CNT_EN to add the beats_left_o counter.
module p2_stride_seq
  import p2_stride_seq_pkg::*;
#(
  parameter int unsigned NrLanes     = 4,
  parameter int unsigned StrideWidth = idx_width(8 * NrLanes),
  parameter int unsigned IdxWidth    = idx_width(StrideWidth)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  p2_stride_seq_if.slave    bus
`ifdef P2_STRIDE_SEQ_CNT_EN
  ,
  output logic [IdxWidth:0] beats_left_o
`endif
);

  typedef enum logic [1:0] {IDLE, EMIT, ZERO} p2_seq_state_e;

  p2_seq_state_e          state_q, state_d;
  logic [StrideWidth-1:0] residual_q, residual_d;
  p2_order_e              order_q, order_d;
  logic [IdxWidth:0]      popc_q, popc_d;
  logic [IdxWidth:0]      popc_in;

  logic [StrideWidth-1:0] pick_onehot;
  logic [IdxWidth-1:0]    pick_idx;
  logic                   pick_last, pick_empty;

  logic                   p2_valid, p2_last, stride_ready;
  logic                   beat_hs, stride_hs;

  p2_stride_pick #(
    .StrideWidth(StrideWidth),
    .IdxWidth   (IdxWidth)
  ) i_pick (
    .residual_i(residual_q),
    .order_i   (order_q),
    .onehot_o  (pick_onehot),
    .idx_o     (pick_idx),
    .last_o    (pick_last),
    .empty_o   (pick_empty)
  );

  always_comb begin
    popc_in = '0;
    for (int i = 0; i < StrideWidth; i++) popc_in = popc_in + (IdxWidth+1)'(bus.stride[i]);
  end

  // ZERO holds an all-zero residual, so the picker's outputs already form its beat.
  always_comb begin
    state_d      = state_q;
    residual_d   = residual_q;
    order_d      = order_q;
    popc_d       = popc_q;
    p2_valid     = (state_q != IDLE);
    p2_last      = p2_valid & (pick_last | pick_empty);
    stride_ready = (state_q == IDLE) | (p2_valid & bus.p2_ready & p2_last);
    beat_hs      = p2_valid & bus.p2_ready & ~flush_i;
    stride_hs    = bus.stride_valid & stride_ready & ~flush_i;
    if (beat_hs) begin
      residual_d = residual_q ^ pick_onehot;
      if (p2_last) state_d = IDLE;
    end
    if (stride_hs) begin
      residual_d = bus.stride;
      order_d    = bus.order;
      popc_d     = popc_in;
      state_d    = (bus.stride != '0) ? EMIT : ZERO;
    end
    if (flush_i) begin
      state_d    = IDLE;
      residual_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      residual_q <= '0;
      order_q    <= P2_LSB_FIRST;
      popc_q     <= '0;
    end else begin
      state_q    <= state_d;
      residual_q <= residual_d;
      order_q    <= order_d;
      popc_q     <= popc_d;
    end
  end

  assign bus.stride_ready = stride_ready;
  assign bus.p2_valid     = p2_valid;
  assign bus.p2_stride    = p2_valid ? pick_onehot : '0;
  assign bus.p2_idx       = p2_valid ? pick_idx : '0;
  assign bus.p2_last      = p2_last;
  assign bus.popc         = popc_q;

`ifdef P2_STRIDE_SEQ_CNT_EN
  logic [IdxWidth:0] beats_left_q, beats_left_d;

  always_comb begin
    beats_left_d = beats_left_q;
    if (beat_hs) beats_left_d = beats_left_q - (IdxWidth+1)'(1);
    if (stride_hs) beats_left_d = (popc_in == '0) ? (IdxWidth+1)'(1) : popc_in;
    if (flush_i) beats_left_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) beats_left_q <= '0;
    else         beats_left_q <= beats_left_d;
  end

  assign beats_left_o = beats_left_q;
`endif

endmodule

// File: tb/tb_p2_stride_seq.sv
// Self-checking bench for p2_stride_seq (StrideWidth=5); a negedge scoreboard
// checks every accepted beat against a bench-side model of the stride.
module tb_p2_stride_seq;
  import p2_stride_seq_pkg::*;

  typedef struct packed {
    logic [4:0] s;
    logic [2:0] idx;
    logic       last;
    logic [3:0] popc;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  int   errors = 0;
  int   checks = 0;
  beat_t exp_q[$];
  beat_t cur;

  always #5 clk = ~clk;

  p2_stride_seq_if #(.StrideWidth(5), .IdxWidth(3)) bus ();

`ifdef P2_STRIDE_SEQ_CNT_EN
  logic [3:0] beats_left;
`endif

  p2_stride_seq #(.NrLanes(4), .StrideWidth(5), .IdxWidth(3)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .flush_i(flush),
    .bus    (bus)
`ifdef P2_STRIDE_SEQ_CNT_EN
    ,
    .beats_left_o(beats_left)
`endif
  );

  always_comb cur = {bus.p2_stride, bus.p2_idx, bus.p2_last, bus.popc};

  function automatic void push_model(input logic [4:0] s, input p2_order_e o);
    int    cnt;
    int    k;
    int    bi;
    beat_t b;
    cnt = 0;
    k   = 0;
    for (int i = 0; i < 5; i++) cnt += int'(s[i]);
    if (cnt == 0) begin
      b = '{s: 5'b0, idx: 3'd0, last: 1'b1, popc: 4'd0};
      exp_q.push_back(b);
    end else begin
      for (int j = 0; j < 5; j++) begin
        bi = (o == P2_LSB_FIRST) ? j : 4 - j;
        if (s[bi]) begin
          k++;
          b.s    = 5'b00001 << bi;
          b.idx  = 3'(bi);
          b.last = (k == cnt);
          b.popc = 4'(cnt);
          exp_q.push_back(b);
        end
      end
    end
  endfunction

  // Scoreboard: push on stride accept, pop and compare on beat accept.
  always @(negedge clk) begin
    if (rst_n && !flush) begin
      if (bus.stride_valid && bus.stride_ready) push_model(bus.stride, bus.order);
      if (bus.p2_valid && bus.p2_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got beat stride=%b idx=%0d, want no beat", cur.s, cur.idx);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          if (cur !== e) begin
            errors++;
            $display("FAIL sb_beat: got stride=%b idx=%0d last=%b popc=%0d, want stride=%b idx=%0d last=%b popc=%0d",
                     cur.s, cur.idx, cur.last, cur.popc, e.s, e.idx, e.last, e.popc);
          end
        end
      end
    end
  end

  task automatic send(input logic [4:0] s, input p2_order_e o);
    bit ok;
    ok = 1'b0;
    bus.stride = s;
    bus.order = o;
    bus.stride_valid = 1'b1;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      if (bus.stride_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.stride_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_timeout: got stride_ready=0 for 20 cycles, want 1");
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++; if (bus.stride_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", bus.stride_ready); end
    checks++; if (bus.p2_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", bus.p2_valid); end
    checks++; if (bus.p2_stride !== 5'b0) begin errors++; $display("FAIL rst_stride: got %b want 0", bus.p2_stride); end
    checks++; if (bus.p2_idx !== 3'd0) begin errors++; $display("FAIL rst_idx: got %0d want 0", bus.p2_idx); end
    checks++; if (bus.p2_last !== 1'b0) begin errors++; $display("FAIL rst_last: got %b want 0", bus.p2_last); end
    checks++; if (bus.popc !== 4'd0) begin errors++; $display("FAIL rst_popc: got %0d want 0", bus.popc); end
`ifdef P2_STRIDE_SEQ_CNT_EN
    checks++; if (beats_left !== 4'd0) begin errors++; $display("FAIL rst_beats_left: got %0d want 0", beats_left); end
`endif
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.stride_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b want 1", bus.stride_ready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_lsb();
    int n, lastpos;
    n = 0; lastpos = 0;
    bus.p2_ready = 1'b1;
    send(5'b10110, P2_LSB_FIRST);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.p2_valid && bus.p2_ready) begin
        n++;
        if (bus.p2_last) lastpos = (lastpos == 0) ? n : -1;
      end
    end
    checks++; if (n != 3) begin errors++; $display("FAIL lsb_beats: got %0d want 3", n); end
    checks++; if (lastpos != 3) begin errors++; $display("FAIL lsb_lastpos: got %0d want 3", lastpos); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL lsb_pending: got %0d beats left want 0", exp_q.size()); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_msb_stall();
    int    n, lastpos;
    bit    held_v;
    beat_t held;
    n = 0; lastpos = 0; held_v = 1'b0; held = '0;
    bus.p2_ready = 1'b0;
    send(5'b10110, P2_MSB_FIRST);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (held_v) begin
        checks++;
        if (cur !== held || bus.p2_valid !== 1'b1) begin
          errors++;
          $display("FAIL stall_hold: got stride=%b idx=%0d last=%b, want stride=%b idx=%0d last=%b",
                   cur.s, cur.idx, cur.last, held.s, held.idx, held.last);
        end
      end
      held_v = bus.p2_valid && !bus.p2_ready;
      held = cur;
      if (bus.p2_valid && bus.p2_ready) begin
        n++;
        if (bus.p2_last) lastpos = (lastpos == 0) ? n : -1;
      end
      @(posedge clk);
      #1 bus.p2_ready = ~bus.p2_ready;
    end
    bus.p2_ready = 1'b1;
    checks++; if (n != 3) begin errors++; $display("FAIL msb_beats: got %0d want 3", n); end
    checks++; if (lastpos != 3) begin errors++; $display("FAIL msb_lastpos: got %0d want 3", lastpos); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL msb_pending: got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_zero();
    int n;
    n = 0;
    bus.p2_ready = 1'b1;
    send(5'b00000, P2_LSB_FIRST);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.p2_valid && bus.p2_ready) n++;
    end
    checks++; if (n != 1) begin errors++; $display("FAIL zero_beats: got %0d want 1", n); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL zero_pending: got %0d want 0", exp_q.size()); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    bus.p2_ready = 1'b1;
    bus.stride = 5'b00001;
    bus.order = P2_LSB_FIRST;
    bus.stride_valid = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1 bus.stride = 5'b11000;
    @(negedge clk);
    checks++; if (bus.p2_last !== 1'b1) begin errors++; $display("FAIL b2b_first_last: got %b want 1", bus.p2_last); end
    checks++; if (bus.stride_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_at_last: got %b want 1", bus.stride_ready); end
    @(posedge clk);
    #1 bus.stride_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++; if (bus.p2_valid !== 1'b1) begin errors++; $display("FAIL b2b_bubble: got valid=%b want 1 at beat %0d", bus.p2_valid, c + 2); end
    end
    @(negedge clk);
    checks++; if (bus.p2_valid !== 1'b0) begin errors++; $display("FAIL b2b_end_valid: got %b want 0", bus.p2_valid); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_pending: got %0d want 0", exp_q.size()); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_abort(input bit use_reset);
    logic [3:0] popc_exp;
    popc_exp = use_reset ? 4'd0 : 4'd5;
    bus.p2_ready = 1'b1;
    send(5'b11111, P2_LSB_FIRST);
    @(negedge clk);
`ifdef P2_STRIDE_SEQ_CNT_EN
    checks++; if (beats_left !== 4'd5) begin errors++; $display("FAIL abort_cnt_start: got %0d want 5", beats_left); end
`endif
    @(posedge clk);
    #1;
    if (use_reset) rst_n = 1'b0;
    else flush = 1'b1;
    @(negedge clk);
`ifdef P2_STRIDE_SEQ_CNT_EN
    checks++; if (beats_left !== 4'd4) begin errors++; $display("FAIL abort_cnt_dec: got %0d want 4", beats_left); end
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    flush = 1'b0;
    exp_q.delete();
    @(negedge clk);
    checks++; if (bus.p2_valid !== 1'b0) begin errors++; $display("FAIL abort_valid(rst=%0d): got %b want 0", use_reset, bus.p2_valid); end
    checks++; if (bus.stride_ready !== 1'b1) begin errors++; $display("FAIL abort_ready(rst=%0d): got %b want 1", use_reset, bus.stride_ready); end
    checks++; if (bus.popc !== popc_exp) begin errors++; $display("FAIL abort_popc(rst=%0d): got %0d want %0d", use_reset, bus.popc, popc_exp); end
`ifdef P2_STRIDE_SEQ_CNT_EN
    checks++; if (beats_left !== 4'd0) begin errors++; $display("FAIL abort_cnt_clear: got %0d want 0", beats_left); end
`endif
    @(negedge clk);
    checks++; if (bus.p2_valid !== 1'b0) begin errors++; $display("FAIL abort_quiet(rst=%0d): got %b want 0", use_reset, bus.p2_valid); end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.stride = '0;
    bus.order = P2_LSB_FIRST;
    bus.stride_valid = 1'b0;
    bus.p2_ready = 1'b0;
    test_reset();
    test_lsb();
    test_msb_stall();
    test_zero();
    test_back_to_back();
    test_abort(1'b0);
    test_abort(1'b1);
    test_lsb();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion within 200000 time units, want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
